// File: rtl/isa.sv
// Shared ISA-level types for the core and its memory-side glue.
// Holds the bus widths, the store-width encoding and the port arbiter states.
package isa;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_access_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IFETCH = 2'd1,
    ARB_DACC   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory bus between the core's fetch and data ports.
// Non-preemptive; data wins over fetch; 1-entry fetch buffer and 1-cycle data response buffer.
module mem_port_arbiter
  import isa::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic [XLEN-1:0]   i_addr,
  output logic              i_miss,
  output logic [ILEN-1:0]   i_data,
  input  logic              d_rd_enable,
  input  logic              d_wr_enable,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wr_data,
  input  mem_access_t       d_wr_access_type,
  output logic              d_miss,
  output logic [XLEN-1:0]   d_rd_data,
  output logic              m_req,
  output logic              m_wr,
  output logic [XLEN-1:0]   m_addr,
  output logic [XLEN-1:0]   m_wr_data,
  output mem_access_t       m_wr_access_type,
  input  logic              m_ack,
  input  logic [XLEN-1:0]   m_rd_data
);

  arb_state_t        state_q, state_d;
  logic              ibuf_valid_q, ibuf_valid_d;
  logic [XLEN-1:0]   ibuf_addr_q, ibuf_addr_d;
  logic [ILEN-1:0]   ibuf_data_q, ibuf_data_d;
  logic              dbuf_valid_q, dbuf_valid_d;
  logic [XLEN-1:0]   dbuf_data_q, dbuf_data_d;
  logic              m_req_q, m_req_d;
  logic              m_wr_q, m_wr_d;
  logic [XLEN-1:0]   m_addr_q, m_addr_d;
  logic [XLEN-1:0]   m_wr_data_q, m_wr_data_d;
  mem_access_t       m_wr_type_q, m_wr_type_d;

  logic d_req;
  logic i_hit;
  logic same_word;

  assign d_req     = d_rd_enable | d_wr_enable;
  assign i_hit     = ibuf_valid_q && (ibuf_addr_q == i_addr);
  assign same_word = (m_addr_q[XLEN-1:2] == ibuf_addr_q[XLEN-1:2]);

  assign i_miss           = !i_hit;
  assign i_data           = ibuf_data_q;
  assign d_miss           = d_req && !dbuf_valid_q;
  assign d_rd_data        = dbuf_data_q;
  assign m_req            = m_req_q;
  assign m_wr             = m_wr_q;
  assign m_addr           = m_addr_q;
  assign m_wr_data        = m_wr_data_q;
  assign m_wr_access_type = m_wr_type_q;

  always_comb begin
    state_d      = state_q;
    ibuf_valid_d = ibuf_valid_q;
    ibuf_addr_d  = ibuf_addr_q;
    ibuf_data_d  = ibuf_data_q;
    // The data response is only presented for one cycle; the core consumes it then.
    dbuf_valid_d = 1'b0;
    dbuf_data_d  = dbuf_data_q;
    m_req_d      = m_req_q;
    m_wr_d       = m_wr_q;
    m_addr_d     = m_addr_q;
    m_wr_data_d  = m_wr_data_q;
    m_wr_type_d  = m_wr_type_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (d_req && !dbuf_valid_q) begin
          state_d     = ARB_DACC;
          m_req_d     = 1'b1;
          m_wr_d      = d_wr_enable;
          m_addr_d    = d_addr;
          m_wr_data_d = d_wr_data;
          m_wr_type_d = d_wr_access_type;
        end else if (!i_hit) begin
          state_d  = ARB_IFETCH;
          m_req_d  = 1'b1;
          m_wr_d   = 1'b0;
          m_addr_d = i_addr;
        end
      end
      ARB_IFETCH: begin
        if (m_ack) begin
          state_d      = ARB_IDLE;
          m_req_d      = 1'b0;
          ibuf_valid_d = 1'b1;
          ibuf_addr_d  = m_addr_q;
          ibuf_data_d  = m_rd_data[ILEN-1:0];
        end
      end
      ARB_DACC: begin
        if (m_ack) begin
          state_d      = ARB_IDLE;
          m_req_d      = 1'b0;
          dbuf_valid_d = 1'b1;
          dbuf_data_d  = m_rd_data;
          // A store into the buffered instruction word makes the buffer stale.
          if (m_wr_q && same_word) begin
            ibuf_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ARB_IDLE;
      ibuf_valid_q <= 1'b0;
      ibuf_addr_q  <= '0;
      ibuf_data_q  <= '0;
      dbuf_valid_q <= 1'b0;
      dbuf_data_q  <= '0;
      m_req_q      <= 1'b0;
      m_wr_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wr_data_q  <= '0;
      m_wr_type_q  <= MEM_WORD;
    end else begin
      state_q      <= state_d;
      ibuf_valid_q <= ibuf_valid_d;
      ibuf_addr_q  <= ibuf_addr_d;
      ibuf_data_q  <= ibuf_data_d;
      dbuf_valid_q <= dbuf_valid_d;
      dbuf_data_q  <= dbuf_data_d;
      m_req_q      <= m_req_d;
      m_wr_q       <= m_wr_d;
      m_addr_q     <= m_addr_d;
      m_wr_data_q  <= m_wr_data_d;
      m_wr_type_q  <= m_wr_type_d;
    end
  end

  // Protocol expectations on the core and memory sides.
  a_no_rd_and_wr : assert property (@(posedge clk) disable iff (!nrst)
    !(d_rd_enable && d_wr_enable));

  a_d_stable : assert property (@(posedge clk) disable iff (!nrst)
    d_miss |=> $stable({d_rd_enable, d_wr_enable, d_addr, d_wr_data, d_wr_access_type}));

  a_ack_needs_req : assert property (@(posedge clk) disable iff (!nrst)
    m_ack |-> m_req_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-by-cycle vector table plus a reset-mid-transaction sequence.
module tb_mem_port_arbiter;
  import isa::*;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic [XLEN-1:0]   i_addr = '0;
  logic              i_miss;
  logic [ILEN-1:0]   i_data;
  logic              d_rd_enable = 1'b0;
  logic              d_wr_enable = 1'b0;
  logic [XLEN-1:0]   d_addr = '0;
  logic [XLEN-1:0]   d_wr_data = '0;
  mem_access_t       d_wr_access_type = MEM_WORD;
  logic              d_miss;
  logic [XLEN-1:0]   d_rd_data;
  logic              m_req;
  logic              m_wr;
  logic [XLEN-1:0]   m_addr;
  logic [XLEN-1:0]   m_wr_data;
  mem_access_t       m_wr_access_type;
  logic              m_ack = 1'b0;
  logic [XLEN-1:0]   m_rd_data = '0;

  mem_port_arbiter dut (
    .clk              (clk),
    .nrst             (nrst),
    .i_addr           (i_addr),
    .i_miss           (i_miss),
    .i_data           (i_data),
    .d_rd_enable      (d_rd_enable),
    .d_wr_enable      (d_wr_enable),
    .d_addr           (d_addr),
    .d_wr_data        (d_wr_data),
    .d_wr_access_type (d_wr_access_type),
    .d_miss           (d_miss),
    .d_rd_data        (d_rd_data),
    .m_req            (m_req),
    .m_wr             (m_wr),
    .m_addr           (m_addr),
    .m_wr_data        (m_wr_data),
    .m_wr_access_type (m_wr_access_type),
    .m_ack            (m_ack),
    .m_rd_data        (m_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ia;
    logic        rd;
    logic        wr;
    logic [31:0] da;
    logic [31:0] wd;
    mem_access_t ty;
    logic        ack;
    logic [31:0] rdat;
    logic        e_imiss;
    logic [31:0] e_idata;
    logic        e_dmiss;
    logic [31:0] e_drd;
    logic        e_mreq;
    logic        e_mwr;
    logic [31:0] e_maddr;
    logic [31:0] e_mwd;
    mem_access_t e_mty;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_row = -1;

  function automatic vec_t mk(
    input logic [31:0] ia, input logic rd, input logic wr, input logic [31:0] da,
    input logic [31:0] wd, input mem_access_t ty, input logic ack, input logic [31:0] rdat,
    input logic eim, input logic [31:0] eid, input logic edm, input logic [31:0] edr,
    input logic emq, input logic emw, input logic [31:0] ema, input logic [31:0] emwd,
    input mem_access_t emt);
    vec_t v;
    v.ia = ia; v.rd = rd; v.wr = wr; v.da = da; v.wd = wd; v.ty = ty; v.ack = ack; v.rdat = rdat;
    v.e_imiss = eim; v.e_idata = eid; v.e_dmiss = edm; v.e_drd = edr;
    v.e_mreq = emq; v.e_mwr = emw; v.e_maddr = ema; v.e_mwd = emwd; v.e_mty = emt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, cur_row, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    i_addr           = v.ia;
    d_rd_enable      = v.rd;
    d_wr_enable      = v.wr;
    d_addr           = v.da;
    d_wr_data        = v.wd;
    d_wr_access_type = v.ty;
    m_ack            = v.ack;
    m_rd_data        = v.rdat;
  endtask

  task automatic compare(input vec_t v);
    chk("i_miss", {31'd0, i_miss}, {31'd0, v.e_imiss});
    if (!v.e_imiss) chk("i_data", i_data, v.e_idata);
    chk("d_miss", {31'd0, d_miss}, {31'd0, v.e_dmiss});
    if (!v.e_dmiss && v.rd) chk("d_rd_data", d_rd_data, v.e_drd);
    chk("m_req", {31'd0, m_req}, {31'd0, v.e_mreq});
    if (v.e_mreq) begin
      chk("m_wr", {31'd0, m_wr}, {31'd0, v.e_mwr});
      chk("m_addr", m_addr, v.e_maddr);
      if (v.e_mwr) begin
        chk("m_wr_data", m_wr_data, v.e_mwd);
        chk("m_wr_access_type", {30'd0, m_wr_access_type}, {30'd0, v.e_mty});
      end
    end
  endtask

  localparam mem_access_t W = MEM_WORD;
  localparam mem_access_t H = MEM_HALF;

  initial begin
    // Cold fetch of 0x0, then hold the PC for five cycles.
    vecs.push_back(mk(32'h0, 0, 0, 32'h0, 32'h0, W, 0, 32'h0,        1, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, W));
    vecs.push_back(mk(32'h0, 0, 0, 32'h0, 32'h0, W, 1, 32'h00000013, 1, 32'h0, 0, 32'h0, 1, 0, 32'h0, 32'h0, W));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(32'h0, 0, 0, 32'h0, 32'h0, W, 0, 32'h0, 0, 32'h00000013, 0, 32'h0, 0, 0, 32'h0, 32'h0, W));
    // Fetch 0x4 and load 0x100 together: data goes first.
    vecs.push_back(mk(32'h4, 1, 0, 32'h100, 32'h0, W, 0, 32'h0,        1, 32'h0, 1, 32'h0,        0, 0, 32'h0,   32'h0, W));
    vecs.push_back(mk(32'h4, 1, 0, 32'h100, 32'h0, W, 1, 32'hDEADBEEF, 1, 32'h0, 1, 32'h0,        1, 0, 32'h100, 32'h0, W));
    vecs.push_back(mk(32'h4, 1, 0, 32'h100, 32'h0, W, 0, 32'h0,        1, 32'h0, 0, 32'hDEADBEEF, 0, 0, 32'h0,   32'h0, W));
    vecs.push_back(mk(32'h4, 0, 0, 32'h0,   32'h0, W, 1, 32'h00100093, 1, 32'h0, 0, 32'h0,        1, 0, 32'h4,   32'h0, W));
    vecs.push_back(mk(32'h4, 0, 0, 32'h0,   32'h0, W, 0, 32'h0,        0, 32'h00100093, 0, 32'h0, 0, 0, 32'h0,   32'h0, W));
    // Store to the buffered instruction word invalidates the fetch buffer.
    vecs.push_back(mk(32'h4, 0, 1, 32'h4, 32'hCAFEBABE, W, 0, 32'h0, 0, 32'h00100093, 1, 32'h0, 0, 0, 32'h0, 32'h0,       W));
    vecs.push_back(mk(32'h4, 0, 1, 32'h4, 32'hCAFEBABE, W, 1, 32'h0, 0, 32'h00100093, 1, 32'h0, 1, 1, 32'h4, 32'hCAFEBABE, W));
    vecs.push_back(mk(32'h4, 0, 1, 32'h4, 32'hCAFEBABE, W, 0, 32'h0, 1, 32'h0,        0, 32'h0, 0, 0, 32'h0, 32'h0,       W));
    vecs.push_back(mk(32'h4, 0, 0, 32'h0, 32'h0, W, 1, 32'h00200113, 1, 32'h0,        0, 32'h0, 1, 0, 32'h4, 32'h0, W));
    vecs.push_back(mk(32'h4, 0, 0, 32'h0, 32'h0, W, 0, 32'h0,        0, 32'h00200113, 0, 32'h0, 0, 0, 32'h0, 32'h0, W));
    // Load to 0x200 stalled 7 cycles while fetch of 0x8 waits.
    vecs.push_back(mk(32'h8, 1, 0, 32'h200, 32'h0, W, 0, 32'h0, 1, 32'h0, 1, 32'h0, 0, 0, 32'h0, 32'h0, W));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(32'h8, 1, 0, 32'h200, 32'h0, W, 0, 32'h0, 1, 32'h0, 1, 32'h0, 1, 0, 32'h200, 32'h0, W));
    vecs.push_back(mk(32'h8, 1, 0, 32'h200, 32'h0, W, 1, 32'h12345678, 1, 32'h0, 1, 32'h0,        1, 0, 32'h200, 32'h0, W));
    vecs.push_back(mk(32'h8, 1, 0, 32'h200, 32'h0, W, 0, 32'h0,        1, 32'h0, 0, 32'h12345678, 0, 0, 32'h0,   32'h0, W));
    vecs.push_back(mk(32'h8, 0, 0, 32'h0,   32'h0, W, 1, 32'h00300193, 1, 32'h0, 0, 32'h0,        1, 0, 32'h8,   32'h0, W));
    vecs.push_back(mk(32'h8, 0, 0, 32'h0,   32'h0, W, 0, 32'h0,        0, 32'h00300193, 0, 32'h0, 0, 0, 32'h0,   32'h0, W));
    // Halfword store to an unrelated word keeps the fetch buffer.
    vecs.push_back(mk(32'h8, 0, 1, 32'h102, 32'h0000BEEF, H, 0, 32'h0, 0, 32'h00300193, 1, 32'h0, 0, 0, 32'h0,   32'h0,       W));
    vecs.push_back(mk(32'h8, 0, 1, 32'h102, 32'h0000BEEF, H, 1, 32'h0, 0, 32'h00300193, 1, 32'h0, 1, 1, 32'h102, 32'h0000BEEF, H));
    vecs.push_back(mk(32'h8, 0, 1, 32'h102, 32'h0000BEEF, H, 0, 32'h0, 0, 32'h00300193, 0, 32'h0, 0, 0, 32'h0,   32'h0,       W));
    vecs.push_back(mk(32'h8, 0, 0, 32'h0,   32'h0,        W, 0, 32'h0, 0, 32'h00300193, 0, 32'h0, 0, 0, 32'h0,   32'h0,       W));

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst m_req", {31'd0, m_req}, 32'd0);
    chk("rst m_wr", {31'd0, m_wr}, 32'd0);
    chk("rst m_addr", m_addr, 32'd0);
    chk("rst m_wr_data", m_wr_data, 32'd0);
    chk("rst m_wr_access_type", {30'd0, m_wr_access_type}, {30'd0, MEM_WORD});
    chk("rst i_data", i_data, 32'd0);
    chk("rst d_rd_data", d_rd_data, 32'd0);
    chk("rst d_miss", {31'd0, d_miss}, 32'd0);
    chk("rst i_miss", {31'd0, i_miss}, 32'd1);

    @(negedge clk);
    nrst = 1'b1;
    for (int r = 0; r < vecs.size(); r++) begin
      cur_row = r;
      apply(vecs[r]);
      #1;
      compare(vecs[r]);
      @(negedge clk);
    end

    // Reset asserted while a fetch is on the bus, then the fetch is reissued.
    cur_row = 1000;
    apply(mk(32'h40, 0, 0, 32'h0, 32'h0, W, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 32'h0, W));
    #1;
    chk("rr i_miss before", {31'd0, i_miss}, 32'd1);
    chk("rr m_req idle", {31'd0, m_req}, 32'd0);
    @(negedge clk);
    #1;
    chk("rr m_req busy", {31'd0, m_req}, 32'd1);
    chk("rr m_addr busy", m_addr, 32'h40);
    #1;
    nrst = 1'b0;
    #1;
    chk("rr m_req dropped", {31'd0, m_req}, 32'd0);
    chk("rr m_addr cleared", m_addr, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("rr m_req after release", {31'd0, m_req}, 32'd0);
    @(negedge clk);
    #1;
    chk("rr m_req reissued", {31'd0, m_req}, 32'd1);
    chk("rr m_wr reissued", {31'd0, m_wr}, 32'd0);
    chk("rr m_addr reissued", m_addr, 32'h40);
    m_ack     = 1'b1;
    m_rd_data = 32'h00400213;
    @(negedge clk);
    m_ack     = 1'b0;
    m_rd_data = 32'h0;
    #1;
    chk("rr i_miss filled", {31'd0, i_miss}, 32'd0);
    chk("rr i_data filled", i_data, 32'h00400213);
    chk("rr m_req done", {31'd0, m_req}, 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
